// File: rtl/servo_output_limiter_pkg.sv
// rtl/servo_output_limiter_pkg.sv - shared servo constants for the output limiter and IIR filter
// Contents:
//   RAILED_LO / RAILED_HI    bit indices of the railed flags (match the filter's railed_in)
//   DEFAULT_SIGNAL_SIZE      default signed sample width
//   DEFAULT_RAIL_CNT_WIDTH   default rail persistence counter width
package servo_output_limiter_pkg;
  localparam int RAILED_LO              = 0;
  localparam int RAILED_HI              = 1;
  localparam int DEFAULT_SIGNAL_SIZE    = 16;
  localparam int DEFAULT_RAIL_CNT_WIDTH = 8;
endpackage

// File: rtl/servo_output_limiter_if.sv
// rtl/servo_output_limiter_if.sv - signal bundle between the servo filter side and the output limiter
// Signals:
//   on_in            enable; low clears the limiter pipeline
//   signal_in        signed filter output
//   min_in, max_in   signed lower / upper rails
//   max_step_in      unsigned max |change| per cycle, 0 disables slew limiting
//   rail_persist_in  cycles of continuous clamping before a railed flag asserts
//   signal_out       signed limited output to the DAC
//   railed_out       [RAILED_LO]=low rail, [RAILED_HI]=high rail
//   cfg_err_out      high while min_in > max_in
// Modports: master drives the inputs, slave is the limiter.
interface servo_output_limiter_if
  import servo_output_limiter_pkg::*;
#(
  parameter int SIGNAL_SIZE    = DEFAULT_SIGNAL_SIZE,
  parameter int RAIL_CNT_WIDTH = DEFAULT_RAIL_CNT_WIDTH
);
  logic                             on_in;
  logic signed [SIGNAL_SIZE-1:0]    signal_in;
  logic signed [SIGNAL_SIZE-1:0]    min_in;
  logic signed [SIGNAL_SIZE-1:0]    max_in;
  logic        [SIGNAL_SIZE-2:0]    max_step_in;
  logic        [RAIL_CNT_WIDTH-1:0] rail_persist_in;
  logic signed [SIGNAL_SIZE-1:0]    signal_out;
  logic        [1:0]                railed_out;
  logic                             cfg_err_out;

  modport master (
    output on_in, signal_in, min_in, max_in, max_step_in, rail_persist_in,
    input  signal_out, railed_out, cfg_err_out
  );

  modport slave (
    input  on_in, signal_in, min_in, max_in, max_step_in, rail_persist_in,
    output signal_out, railed_out, cfg_err_out
  );
endinterface

// File: rtl/servo_slew_limiter.sv
// rtl/servo_slew_limiter.sv - next-value step logic for the limiter's slew stage
// Ports:
//   target_in    signed clamped value the output is heading for
//   current_in   signed current registered output
//   max_step_in  unsigned max |change| per cycle, 0 passes target_in straight through
//   next_out     signed value to register as the new output
module servo_slew_limiter #(
  parameter int SIGNAL_SIZE = 16
) (
  input  logic signed [SIGNAL_SIZE-1:0] target_in,
  input  logic signed [SIGNAL_SIZE-1:0] current_in,
  input  logic        [SIGNAL_SIZE-2:0] max_step_in,
  output logic signed [SIGNAL_SIZE-1:0] next_out
);
  // One extra bit so the distance between any two samples is exact.
  logic signed [SIGNAL_SIZE:0]   diff;
  logic signed [SIGNAL_SIZE:0]   step_ext;
  logic signed [SIGNAL_SIZE-1:0] step_ss;
  logic signed [SIGNAL_SIZE-1:0] step_up;
  logic signed [SIGNAL_SIZE-1:0] step_dn;

  assign diff     = {target_in[SIGNAL_SIZE-1], target_in} - {current_in[SIGNAL_SIZE-1], current_in};
  assign step_ext = $signed({2'b00, max_step_in});
  assign step_ss  = $signed({1'b0, max_step_in});

  // These sums are only selected when the target lies beyond them, so the
  // selected result always fits and never wraps.
  assign step_up = current_in + step_ss;
  assign step_dn = current_in - step_ss;

  always_comb begin
    next_out = target_in;
    if (max_step_in != '0) begin
      if (diff > step_ext) begin
        next_out = step_up;
      end else if (diff < -step_ext) begin
        next_out = step_dn;
      end
    end
  end
endmodule

// File: rtl/servo_output_limiter.sv
// rtl/servo_output_limiter.sv - rail clamp, slew limit and railed flags between the servo filter and DAC
// Ports:
//   clk_in  system clock
//   rst_in  asynchronous active-high reset, clears every register
//   bus     servo_output_limiter_if slave: on_in, signal_in, min_in, max_in,
//           max_step_in, rail_persist_in in; signal_out, railed_out, cfg_err_out out
// Pipeline: stage 1 registers the clamped sample and rail hits, stage 2
// registers the slew-limited output, the railed flags and the rail counters.
module servo_output_limiter
  import servo_output_limiter_pkg::*;
#(
  parameter int SIGNAL_SIZE    = DEFAULT_SIGNAL_SIZE,
  parameter int RAIL_CNT_WIDTH = DEFAULT_RAIL_CNT_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  servo_output_limiter_if.slave  bus
);
  localparam logic [RAIL_CNT_WIDTH-1:0] CNT_ONE = RAIL_CNT_WIDTH'(1);

  logic signed [SIGNAL_SIZE-1:0]    clamp_d;
  logic                             lo_hit_d;
  logic                             hi_hit_d;
  logic                             cfg_err_d;

  logic signed [SIGNAL_SIZE-1:0]    clamped_q;
  logic                             lo_hit_q;
  logic                             hi_hit_q;
  logic                             cfg_err_q;
  logic        [RAIL_CNT_WIDTH-1:0] cnt_lo_q;
  logic        [RAIL_CNT_WIDTH-1:0] cnt_hi_q;
  logic        [1:0]                railed_q;
  logic        [1:0]                railed_d;
  logic signed [SIGNAL_SIZE-1:0]    out_q;
  logic signed [SIGNAL_SIZE-1:0]    slew_next;

  // Stage 1: clamp. With crossed rails the output parks on min_in and no
  // hit is reported, so the filter never sees a railed flag from a bad config.
  always_comb begin
    clamp_d   = bus.signal_in;
    lo_hit_d  = 1'b0;
    hi_hit_d  = 1'b0;
    cfg_err_d = (bus.min_in > bus.max_in);
    if (cfg_err_d) begin
      clamp_d = bus.min_in;
    end else if (bus.signal_in < bus.min_in) begin
      clamp_d  = bus.min_in;
      lo_hit_d = 1'b1;
    end else if (bus.signal_in > bus.max_in) begin
      clamp_d  = bus.max_in;
      hi_hit_d = 1'b1;
    end
  end

  servo_slew_limiter #(
    .SIGNAL_SIZE (SIGNAL_SIZE)
  ) u_slew (
    .target_in   (clamped_q),
    .current_in  (out_q),
    .max_step_in (bus.max_step_in),
    .next_out    (slew_next)
  );

  // The counters hold the number of earlier consecutive hit cycles, so with
  // rail_persist_in=0 the flag rises together with the first clamped output.
  always_comb begin
    railed_d            = 2'b00;
    railed_d[RAILED_LO] = lo_hit_q && (cnt_lo_q >= bus.rail_persist_in);
    railed_d[RAILED_HI] = hi_hit_q && (cnt_hi_q >= bus.rail_persist_in);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      clamped_q <= '0;
      lo_hit_q  <= 1'b0;
      hi_hit_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_lo_q  <= '0;
      cnt_hi_q  <= '0;
      railed_q  <= 2'b00;
      out_q     <= '0;
    end else if (!bus.on_in) begin
      clamped_q <= '0;
      lo_hit_q  <= 1'b0;
      hi_hit_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      cnt_lo_q  <= '0;
      cnt_hi_q  <= '0;
      railed_q  <= 2'b00;
      out_q     <= '0;
    end else begin
      clamped_q <= clamp_d;
      lo_hit_q  <= lo_hit_d;
      hi_hit_q  <= hi_hit_d;
      cfg_err_q <= cfg_err_d;
      cnt_lo_q  <= !lo_hit_q ? '0 : (&cnt_lo_q ? cnt_lo_q : cnt_lo_q + CNT_ONE);
      cnt_hi_q  <= !hi_hit_q ? '0 : (&cnt_hi_q ? cnt_hi_q : cnt_hi_q + CNT_ONE);
      railed_q  <= railed_d;
      out_q     <= slew_next;
    end
  end

  assign bus.signal_out  = out_q;
  assign bus.railed_out  = railed_q;
  assign bus.cfg_err_out = cfg_err_q;
endmodule

// File: tb/tb_servo_output_limiter.sv
// tb/tb_servo_output_limiter.sv - self-checking bench for servo_output_limiter
module tb_servo_output_limiter;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    int          due;
    logic [15:0] out;
    logic [1:0]  railed;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  servo_output_limiter_if #(.SIGNAL_SIZE(16), .RAIL_CNT_WIDTH(8)) bus ();

  servo_output_limiter #(.SIGNAL_SIZE(16), .RAIL_CNT_WIDTH(8)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic signed [15:0] o, input logic [1:0] r, input logic er);
    sb.push_back('{due: cyc + 2, out: o, railed: r, err: er});
  endtask

  task automatic test_reset();
    logic [18:0] got;
    #12;
    got = {bus.signal_out, bus.railed_out, bus.cfg_err_out};
    checks++;
    if (got !== 19'd0) begin
      failures++; $display("FAIL reset_state got=%h exp=0", got);
    end
    tick(); rst_in = 1'b0;
    bus.min_in = -16'sd100; bus.max_in = 16'sd100; bus.signal_in = 16'sd1000;
    repeat (3) tick();
    got = {bus.signal_out, bus.railed_out, bus.cfg_err_out};
    checks++;
    if (got !== {16'sd100, 2'b10, 1'b0}) begin
      failures++; $display("FAIL pre_reset got=%h exp=%h", got, {16'sd100, 2'b10, 1'b0});
    end
    #2 rst_in = 1'b1;
    #1;
    got = {bus.signal_out, bus.railed_out, bus.cfg_err_out};
    checks++;
    if (got !== 19'd0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", got);
    end
    tick(); rst_in = 1'b0;
    repeat (3) tick();
    got = {bus.signal_out, bus.railed_out, bus.cfg_err_out};
    checks++;
    if (got !== {16'sd100, 2'b10, 1'b0}) begin
      failures++; $display("FAIL recover got=%h exp=%h", got, {16'sd100, 2'b10, 1'b0});
    end
    bus.on_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = {bus.signal_out, bus.railed_out, bus.cfg_err_out};
      checks++;
      if (got !== 19'd0) begin
        failures++; $display("FAIL on_off cycle=%0d got=%h exp=0", k, got);
      end
    end
    bus.on_in = 1'b1; bus.signal_in = 16'sd0;
    repeat (3) tick();
  endtask

  task automatic test_clamp();
    logic signed [15:0] sig [4]  = '{16'sd50, 16'sd300, -16'sd300, 16'sd100};
    logic signed [15:0] xo  [4]  = '{16'sd50, 16'sd100, -16'sd100, 16'sd100};
    logic        [1:0]  xr  [4]  = '{2'b00, 2'b10, 2'b01, 2'b00};
    bus.min_in = -16'sd100; bus.max_in = 16'sd100;
    bus.max_step_in = '0; bus.rail_persist_in = '0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        bus.signal_in = sig[k];
        push(xo[k], xr[k], 1'b0);
      end
      tick();
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({bus.signal_out, bus.railed_out, bus.cfg_err_out} !== {e.out, e.railed, e.err}) begin
          failures++;
          $display("FAIL clamp cyc=%0d got out=%0d railed=%b err=%b exp out=%0d railed=%b err=%b",
                   cyc, bus.signal_out, bus.railed_out, bus.cfg_err_out, $signed(e.out), e.railed, e.err);
        end
      end
    end
  endtask

  task automatic test_persist();
    bus.rail_persist_in = 8'd3;
    for (int k = 0; k < 16; k++) begin
      if (k < 14) begin
        if (k < 3 || k >= 11) begin
          bus.signal_in = 16'sd0;
          push(16'sd0, 2'b00, 1'b0);
        end else begin
          bus.signal_in = 16'sd500;
          push(16'sd100, (k - 3 >= 3) ? 2'b10 : 2'b00, 1'b0);
        end
      end
      tick();
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({bus.signal_out, bus.railed_out, bus.cfg_err_out} !== {e.out, e.railed, e.err}) begin
          failures++;
          $display("FAIL persist cyc=%0d got out=%0d railed=%b err=%b exp out=%0d railed=%b err=%b",
                   cyc, bus.signal_out, bus.railed_out, bus.cfg_err_out, $signed(e.out), e.railed, e.err);
        end
      end
    end
    bus.rail_persist_in = '0;
  endtask

  task automatic test_slew();
    logic signed [15:0] sig [12] = '{0, 0, 35, 35, 35, 35, 35, -5, -5, -5, -5, -5};
    logic signed [15:0] xo  [12] = '{0, 0, 10, 20, 30, 35, 35, 25, 15, 5, -5, -5};
    bus.min_in = -16'sd32768; bus.max_in = 16'sd32767; bus.max_step_in = 15'd10;
    for (int k = 0; k < 14; k++) begin
      if (k < 12) begin
        bus.signal_in = sig[k];
        push(xo[k], 2'b00, 1'b0);
      end
      tick();
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({bus.signal_out, bus.railed_out, bus.cfg_err_out} !== {e.out, e.railed, e.err}) begin
          failures++;
          $display("FAIL slew cyc=%0d got out=%0d railed=%b err=%b exp out=%0d railed=%b err=%b",
                   cyc, bus.signal_out, bus.railed_out, bus.cfg_err_out, $signed(e.out), e.railed, e.err);
        end
      end
    end
  endtask

  task automatic test_extremes();
    for (int k = 0; k < 11; k++) begin
      if (k < 3) begin
        bus.max_step_in = '0; bus.signal_in = 16'sd32767;
        push(16'sd32767, 2'b00, 1'b0);
      end else if (k < 9) begin
        bus.max_step_in = 15'd1; bus.signal_in = -16'sd32768;
        push(16'(32766 - (k - 3)), 2'b00, 1'b0);
      end
      tick();
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({bus.signal_out, bus.railed_out, bus.cfg_err_out} !== {e.out, e.railed, e.err}) begin
          failures++;
          $display("FAIL extremes cyc=%0d got out=%0d railed=%b err=%b exp out=%0d railed=%b err=%b",
                   cyc, bus.signal_out, bus.railed_out, bus.cfg_err_out, $signed(e.out), e.railed, e.err);
        end
      end
    end
  endtask

  task automatic test_invalid_cfg();
    logic signed [15:0] sig [5] = '{16'sd0, 16'sd1000, -16'sd1000, 16'sd50, 16'sd0};
    bus.max_step_in = '0; bus.min_in = 16'sd50; bus.max_in = -16'sd50;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        bus.signal_in = sig[k];
        push(16'sd50, 2'b00, 1'b1);
      end
      tick();
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if ({bus.signal_out, bus.railed_out, bus.cfg_err_out} !== {e.out, e.railed, e.err}) begin
          failures++;
          $display("FAIL invalid_cfg cyc=%0d got out=%0d railed=%b err=%b exp out=%0d railed=%b err=%b",
                   cyc, bus.signal_out, bus.railed_out, bus.cfg_err_out, $signed(e.out), e.railed, e.err);
        end
      end
    end
  endtask

  initial begin
    bus.on_in = 1'b1;
    bus.signal_in = '0;
    bus.min_in = '0;
    bus.max_in = '0;
    bus.max_step_in = '0;
    bus.rail_persist_in = '0;
    test_reset();
    test_clamp();
    test_persist();
    test_slew();
    test_extremes();
    test_invalid_cfg();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
